mem_fill_ctrl: RTL
==================

// Module: mem_fill_ctrl
// PURPOSE
//  Miss-handling / main-memory controller between the split I-cache and D-cache and the single-port pipelined
//  main memory. Arbitrates I-fills, D-fills and D write-through stores onto one memory port.
//  For a fill it streams the 8-word block into the requesting cache's data array and signals completion.
//  Pipeline stalls on icache/dcache miss until the matching *_fill_done pulse.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  DATA_W       16  word width (2 bytes/word)
//  BLK_WORDS     8  words per cache block (16-byte block); power of 2
//  MEM_LAT       4  memory read latency, cycles from issue to mem_data_valid (bench/timing reference only)
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  imiss            in   1       I-cache miss, level, held until ifill_done
//  imiss_addr       in   ADDR_W  missing I address (any byte in block)
//  dmiss            in   1       D-cache miss, level, held until dfill_done
//  dmiss_addr       in   ADDR_W  missing D address
//  dwr_req          in   1       D write-through store, level, held until dwr_ack
//  dwr_addr         in   ADDR_W  store address
//  dwr_data         in   DATA_W  store data
//  ifill_we         out  1       write fill_data into I-cache at fill_word
//  dfill_we         out  1       write fill_data into D-cache at fill_word
//  fill_word        out  log2(BLK_WORDS)  word index within block being written
//  fill_data        out  DATA_W  fill word (= mem_data_in)
//  ifill_done       out  1       1-cycle pulse: I block complete, tag may be validated
//  dfill_done       out  1       1-cycle pulse: D block complete
//  dwr_ack          out  1       1-cycle pulse: store issued to memory
//  mem_en           out  1       memory access this cycle
//  mem_wr           out  1       1=write, 0=read (valid with mem_en)
//  mem_addr         out  ADDR_W  memory byte address
//  mem_data_out     out  DATA_W  store data to memory
//  mem_data_in      in   DATA_W  read data from memory
//  mem_data_valid   in   1       mem_data_in valid this cycle
// BEHAVIOUR
//  States: IDLE, FILL, DONE, WRITE. Reset (async): state=IDLE, counters=0, every output 0.
//  IDLE arbitration, sampled each edge, priority dmiss > dwr_req > imiss:
//   dmiss -> FILL (target D); else dwr_req -> WRITE; else imiss -> FILL (target I); else stay.
//  On entry to FILL latch base = {miss_addr[ADDR_W-1:4], 4'b0}, issue_cnt=0, recv_cnt=0.
//  FILL issue: while issue_cnt<BLK_WORDS, mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt++ each cycle
//   (one read per cycle, 8 consecutive cycles, first in the first FILL cycle); afterwards mem_en=0.
//  FILL receive: when mem_data_valid, target *fill_we=1 combinationally, fill_word=recv_cnt,
//   fill_data=mem_data_in; recv_cnt++ (wraps to 0 after last). Non-target fill_we stays 0.
//  On the BLK_WORDS-th valid -> DONE. DONE: target *_fill_done=1 for exactly one cycle -> IDLE.
//  Requester drops miss after done; IDLE re-arbitrates next edge, so back-to-back fills have a 2-cycle gap
//   from last fill write to next first issue (DONE + IDLE).
//  mem_data_valid in IDLE/DONE/WRITE ignored (no fill_we). Order of returns is in-order; no reordering.
//  WRITE: one cycle, mem_en=1, mem_wr=1, mem_addr=dwr_addr, mem_data_out=dwr_data, dwr_ack=1 -> IDLE.
//  Requests arriving while not IDLE are held by requester; never dropped, never preempt a fill.
//  Simultaneous dmiss+imiss: D served fully first, I served next. dmiss+dwr_req: miss first.
//  Reset mid-fill: immediate abort to IDLE, no done pulse; memory shares rst_n so no stale valids.
//  Latency, MEM_LAT=4, idle start: request seen edge E0; issues cycles 1..8; writes cycles 5..12;
//   done cycle 13.
// TESTING
//  dmiss=1, dmiss_addr=0x123A, mem returns base+idx pattern -> reads 0x1230..0x123E, dfill_we 8 cycles idx 0..7, dfill_done 1 cycle later.
//  imiss and dmiss asserted same cycle -> full D fill (dfill_done) first, then I fill; ifill_we never overlaps dfill_we.
//  dwr_req addr 0x0040 data 0xBEEF while idle -> one cycle mem_en=1, mem_wr=1, addr 0x0040, data 0xBEEF, dwr_ack pulse.
//  memory with gaps in mem_data_valid (valid every other cycle) -> still exactly 8 writes, indices 0..7, done after 8th.
//  rst_n low after 3rd fill write -> all outputs 0 asynchronously, state IDLE; new imiss later completes cleanly.
//  dwr_req raised during a D fill -> no memory write until after dfill_done; then WRITE cycle with dwr_ack.

Source files
------------

// File: rtl/mem_fill_ctrl.sv
// rtl/mem_fill_ctrl.sv - miss-fill / write-through arbiter between split I/D caches and one pipelined memory port
module mem_fill_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         imiss,
  input  logic [ADDR_W-1:0]            imiss_addr,
  input  logic                         dmiss,
  input  logic [ADDR_W-1:0]            dmiss_addr,
  input  logic                         dwr_req,
  input  logic [ADDR_W-1:0]            dwr_addr,
  input  logic [DATA_W-1:0]            dwr_data,
  output logic                         ifill_we,
  output logic                         dfill_we,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         ifill_done,
  output logic                         dfill_done,
  output logic                         dwr_ack,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data_out,
  input  logic [DATA_W-1:0]            mem_data_in,
  input  logic                         mem_data_valid
);

  localparam int IDX_W = $clog2(BLK_WORDS);
  // Clears the byte offset within a block (BLK_WORDS words of 2 bytes).
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * BLK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic               tgt_d_q, tgt_d_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W:0]     issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic               issuing;
  logic               fill_wr;

  always_comb begin
    issuing = (state_q == S_FILL) && !issue_cnt_q[IDX_W];
    fill_wr = (state_q == S_FILL) && mem_data_valid;

    ifill_we     = fill_wr && !tgt_d_q;
    dfill_we     = fill_wr && tgt_d_q;
    fill_word    = fill_wr ? recv_cnt_q : '0;
    fill_data    = fill_wr ? mem_data_in : '0;
    ifill_done   = (state_q == S_DONE) && !tgt_d_q;
    dfill_done   = (state_q == S_DONE) && tgt_d_q;
    dwr_ack      = (state_q == S_WRITE);
    mem_en       = issuing || (state_q == S_WRITE);
    mem_wr       = (state_q == S_WRITE);
    mem_addr     = '0;
    mem_data_out = '0;
    if (state_q == S_WRITE) begin
      mem_addr     = dwr_addr;
      mem_data_out = dwr_data;
    end else if (issuing) begin
      mem_addr = base_q + (ADDR_W'(issue_cnt_q) << 1);
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d_d     = tgt_d_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      S_IDLE: begin
        // Priority: D miss, then store, then I miss.
        if (dmiss) begin
          state_d     = S_FILL;
          tgt_d_d     = 1'b1;
          base_d      = dmiss_addr & BLK_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end else if (dwr_req) begin
          state_d = S_WRITE;
        end else if (imiss) begin
          state_d     = S_FILL;
          tgt_d_d     = 1'b0;
          base_d      = imiss_addr & BLK_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      S_FILL: begin
        if (issuing) issue_cnt_d = issue_cnt_q + (IDX_W + 1)'(1);
        if (mem_data_valid) begin
          recv_cnt_d = recv_cnt_q + IDX_W'(1);
          if (&recv_cnt_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tgt_d_q     <= 1'b0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tgt_d_q     <= tgt_d_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule
